// File: rtl/alu_result_collector.sv
// Two-entry result FIFO with a saturating accumulator, a push counter and sticky status
// flags. The accumulator, counter and flags advance on push only.
module alu_result_collector #(
    parameter int DEPTH = 2,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       in_op,
    input  logic [7:0]       in_result,
    output logic             in_ready,
    output logic             out_valid,
    output logic [1:0]       out_op,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    input  logic             clr,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf,
    output logic [7:0]       txn_cnt,
    output logic             err_op
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [9:0]       mem_q [DEPTH];

    logic [ACC_W-1:0] acc_q, acc_d, acc_base;
    logic [ACC_W:0]   sum;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             push;
    logic             pop;

    // Handshakes use only the registered flags, so in_ready never depends on out_ready.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop && !push) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the two storage entries are reset so the head reads zero out of reset;
    // at this depth that costs only a handful of flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {in_op, in_result};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        acc_base = clr ? '0 : acc_q;
        ovf_d    = clr ? 1'b0 : ovf_q;
        err_d    = clr ? 1'b0 : err_q;
        cnt_d    = clr ? 8'd0 : cnt_q;
        sum      = {1'b0, acc_base} + {{(ACC_W - 7){1'b0}}, in_result};
        acc_d    = acc_base;
        if (push) begin
            if (sum[ACC_W]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
            err_d = err_d | (in_op == 2'b10);
            cnt_d = cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_op    = mem_q[rd_ptr_q][9:8];
    assign out_data  = mem_q[rd_ptr_q][7:0];
    assign acc       = acc_q;
    assign acc_ovf   = ovf_q;
    assign txn_cnt   = cnt_q;
    assign err_op    = err_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: a queue scoreboard tracks FIFO contents and a
// small arithmetic model tracks the accumulator, counter and sticky flags.
module tb_alu_result_collector;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [7:0]  in_result;
    logic        in_ready;
    logic        out_valid;
    logic [1:0]  out_op;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        clr;
    logic [11:0] acc;
    logic        acc_ovf;
    logic [7:0]  txn_cnt;
    logic        err_op;

    int          errors = 0;
    int          checks = 0;
    string       phase  = "reset";

    logic [9:0]  exp_q[$];
    int          m_acc = 0;
    bit          m_ovf = 1'b0;
    bit          m_err = 1'b0;
    int          m_cnt = 0;

    alu_result_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_result (in_result),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_op    (out_op),
        .out_data  (out_data),
        .out_ready (out_ready),
        .clr       (clr),
        .acc       (acc),
        .acc_ovf   (acc_ovf),
        .txn_cnt   (txn_cnt),
        .err_op    (err_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_op", out_op, 0);
        check("rst_acc", acc, 0);
        check("rst_acc_ovf", acc_ovf, 0);
        check("rst_err_op", err_op, 0);
        check("rst_txn_cnt", txn_cnt, 0);
    endtask

    // Called at a falling edge with inputs already driven; checks the handshake and head,
    // advances over one rising edge, updates the model, then checks the accumulator side.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            bit exp_rdy;
            bit exp_vld;
            bit do_push;
            bit do_pop;
            exp_rdy = (exp_q.size() < 2);
            exp_vld = (exp_q.size() != 0);
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, exp_vld);
            if (exp_vld) begin
                check("out_data", out_data, exp_q[0][7:0]);
                check("out_op", out_op, exp_q[0][9:8]);
            end
            do_push = in_valid && exp_rdy;
            do_pop  = out_ready && exp_vld;
            @(negedge clk);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({in_op, in_result});
            if (clr) begin
                m_acc = 0;
                m_ovf = 1'b0;
                m_err = 1'b0;
                m_cnt = 0;
            end
            if (do_push) begin
                m_acc = m_acc + int'(in_result);
                if (m_acc > 4095) begin
                    m_acc = 4095;
                    m_ovf = 1'b1;
                end
                if (in_op == 2'b10) m_err = 1'b1;
                m_cnt = (m_cnt + 1) % 256;
            end
            check("acc", acc, m_acc);
            check("acc_ovf", acc_ovf, m_ovf);
            check("err_op", err_op, m_err);
            check("txn_cnt", txn_cnt, m_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_result = 8'h00;
        out_ready = 1'b0;
        clr       = 1'b0;
        #12;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // Single push into an empty FIFO appears one cycle later.
        phase     = "push_2d";
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_result = 8'h2D;
        tick(1);
        in_valid = 1'b0;
        check("out_valid_1cyc", out_valid, 1);
        check("out_data_2d", out_data, 8'h2D);
        check("acc_2d", acc, 12'h02D);
        tick(1);
        out_ready = 1'b1;
        tick(2);
        out_ready = 1'b0;

        // Back-to-back pushes fill the FIFO; the third is held until space opens.
        phase = "fill_full";
        clr   = 1'b1;
        tick(1);
        clr       = 1'b0;
        in_valid  = 1'b1;
        in_result = 8'h10;
        tick(1);
        in_result = 8'h20;
        tick(1);
        in_result = 8'h30;
        tick(2);
        check("full_in_ready", in_ready, 0);
        check("full_acc", acc, 12'h030);
        out_ready = 1'b1;
        tick(2);
        in_valid = 1'b0;
        tick(2);
        out_ready = 1'b0;

        // Saturation after seventeen 0xFF pushes.
        phase = "saturate";
        clr   = 1'b1;
        tick(1);
        clr       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 2'b11;
        in_result = 8'hFF;
        tick(16);
        check("acc_16", acc, 12'hFF0);
        check("ovf_16", acc_ovf, 0);
        tick(1);
        check("acc_17", acc, 12'hFFF);
        check("ovf_17", acc_ovf, 1);
        check("cnt_17", txn_cnt, 17);
        in_valid = 1'b0;
        tick(2);

        // Clear coincident with a push restarts from the pushed value.
        phase     = "clr_push";
        clr       = 1'b1;
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_result = 8'h07;
        tick(1);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clrpush_acc", acc, 12'h007);
        check("clrpush_ovf", acc_ovf, 0);
        check("clrpush_cnt", txn_cnt, 1);
        tick(1);
        clr = 1'b1;
        tick(1);
        clr       = 1'b0;
        in_valid  = 1'b1;
        in_result = 8'h80;
        tick(10);
        in_valid = 1'b0;
        check("acc_500", acc, 12'h500);
        tick(1);
        clr       = 1'b1;
        in_valid  = 1'b1;
        in_result = 8'h07;
        tick(1);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr500_acc", acc, 12'h007);
        tick(1);

        // Reserved op code sets err_op; a bare clear leaves the FIFO entry in place.
        phase     = "err_op";
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b10;
        in_result = 8'h5A;
        tick(1);
        in_valid = 1'b0;
        check("err_set", err_op, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("err_clr", err_op, 0);
        check("clr_keeps_entry", out_valid, 1);
        out_ready = 1'b1;
        tick(2);
        out_ready = 1'b0;

        // Reset while full discards everything immediately.
        phase = "reset_full";
        clr   = 1'b1;
        tick(1);
        clr       = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b01;
        in_result = 8'hFF;
        tick(1);
        in_result = 8'h24;
        tick(1);
        in_valid = 1'b0;
        tick(1);
        check("pre_rst_acc", acc, 12'h123);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        m_err = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_result = 8'h01;
        tick(1);
        in_valid = 1'b0;
        check("post_rst_acc", acc, 12'h001);
        check("post_rst_data", out_data, 8'h01);
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
